// File: rtl/register_write_controller.sv
// Write-request packet decoder: assembles address + big-endian data from the UART Rx stream,
// issues a one-cycle register write and returns a one-byte acknowledge packet on the Tx stream.
// UART_PACKET is carried flat as {Source, Destination, Length, Data, SoP, EoP, Valid} (35 bits).
module register_write_controller #(
    parameter int unsigned DATA_LENGTH = 4,
    parameter logic [7:0]  WRITE_DEST  = 8'h01,
    parameter logic [7:0]  ACK_SOURCE  = 8'h01
) (
    input  logic        ipClk,
    input  logic        ipnReset,
    input  logic [34:0] ipRxStream,
    input  logic        ipTxReady,
    output logic [34:0] opTxStream,
    output logic [7:0]  opAddress,
    output logic [31:0] opWriteData,
    output logic        opWrite,
    output logic        opError,
    output logic        opAckOverrun
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StGetData = 2'd1;
    localparam logic [1:0] StWrite   = 2'd2;

    localparam logic [7:0] ReqLen  = 8'(DATA_LENGTH + 1);
    localparam logic [2:0] CntInit = 3'(DATA_LENGTH);

    logic [7:0] rx_src, rx_dst, rx_len, rx_data;
    logic       rx_sop, rx_eop, rx_valid;

    assign {rx_src, rx_dst, rx_len, rx_data, rx_sop, rx_eop, rx_valid} = ipRxStream;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  addr_lat_q, addr_lat_d;
    logic [7:0]  src_lat_q, src_lat_d;
    logic [23:0] shreg_q, shreg_d;
    logic [7:0]  address_q, address_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        error_q, error_d;
    logic        overrun_q, overrun_d;
    logic [34:0] tx_q, tx_d;

    logic req_hit, req_ok, start, commit;

    assign req_hit = rx_valid && rx_sop && (rx_dst == WRITE_DEST);
    assign req_ok  = req_hit && (rx_len == ReqLen) && !rx_eop;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_lat_d = addr_lat_q;
        src_lat_d  = src_lat_q;
        shreg_d    = shreg_q;
        address_d  = address_q;
        wdata_d    = wdata_q;
        write_d    = 1'b0;
        error_d    = 1'b0;
        overrun_d  = 1'b0;
        tx_d       = tx_q;
        start      = 1'b0;
        commit     = 1'b0;

        // Handshake completes on this edge; remaining fields are left as they were.
        if (tx_q[0] && ipTxReady) begin
            tx_d[0] = 1'b0;
        end

        case (state_q)
            StGetData: begin
                if (rx_valid) begin
                    if (rx_sop) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                        start   = req_ok;
                    end else begin
                        shreg_d = {shreg_q[15:0], rx_data};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            if (rx_eop) begin
                                commit = 1'b1;
                            end else begin
                                error_d = 1'b1;
                                state_d = StIdle;
                            end
                        end else if (rx_eop) begin
                            error_d = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                if (req_hit) begin
                    if (req_ok) begin
                        start = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
        endcase

        if (start) begin
            state_d    = StGetData;
            addr_lat_d = rx_data;
            src_lat_d  = rx_src;
            shreg_d    = '0;
            cnt_d      = CntInit;
        end

        if (commit) begin
            state_d   = StWrite;
            write_d   = 1'b1;
            address_d = addr_lat_q;
            wdata_d   = {shreg_q, rx_data};
            // An ack still waiting for the transmitter is kept; the new one is dropped.
            if (tx_q[0] && !ipTxReady) begin
                overrun_d = 1'b1;
            end else begin
                tx_d = {ACK_SOURCE, src_lat_q, 8'd1, addr_lat_q, 3'b111};
            end
        end
    end

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_lat_q <= '0;
            src_lat_q  <= '0;
            shreg_q    <= '0;
            address_q  <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
            tx_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_lat_q <= addr_lat_d;
            src_lat_q  <= src_lat_d;
            shreg_q    <= shreg_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            error_q    <= error_d;
            overrun_q  <= overrun_d;
            tx_q       <= tx_d;
        end
    end

    assign opTxStream   = tx_q;
    assign opAddress    = address_q;
    assign opWriteData  = wdata_q;
    assign opWrite      = write_q;
    assign opError      = error_q;
    assign opAckOverrun = overrun_q;

endmodule

// File: tb/tb_register_write_controller.sv
// Bench for register_write_controller: directed scenarios plus randomized packets, all outputs
// compared every cycle against a byte-counting packet model.
module tb_register_write_controller;

    localparam int unsigned DL    = 4;
    localparam logic [7:0]  WDEST = 8'h01;
    localparam logic [7:0]  ASRC  = 8'h01;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ready = 1'b1;
    logic [34:0] rx    = '0;
    logic [34:0] rx2   = '0;
    logic        chk_en  = 1'b0;
    logic        rand_rdy = 1'b0;

    logic [34:0] tx, tx2;
    logic [7:0]  addr, addr2;
    logic [31:0] wdata, wdata2;
    logic        wr, wr2, err, err2, ovr, ovr2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_write_controller #(
        .DATA_LENGTH(DL),
        .WRITE_DEST (WDEST),
        .ACK_SOURCE (ASRC)
    ) u_dut (
        .ipClk       (clk),
        .ipnReset    (rst_n),
        .ipRxStream  (rx),
        .ipTxReady   (ready),
        .opTxStream  (tx),
        .opAddress   (addr),
        .opWriteData (wdata),
        .opWrite     (wr),
        .opError     (err),
        .opAckOverrun(ovr)
    );

    register_write_controller #(
        .DATA_LENGTH(2),
        .WRITE_DEST (WDEST),
        .ACK_SOURCE (ASRC)
    ) u_dut2 (
        .ipClk       (clk),
        .ipnReset    (rst_n),
        .ipRxStream  (rx2),
        .ipTxReady   (1'b1),
        .opTxStream  (tx2),
        .opAddress   (addr2),
        .opWriteData (wdata2),
        .opWrite     (wr2),
        .opError     (err2),
        .opAckOverrun(ovr2)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks the open request as a byte count plus accumulated value.
    logic        in_req;
    int          n_got;
    logic [31:0] acc;
    logic [7:0]  h_src, h_addr;
    logic        m_wr, m_err, m_ovr;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [34:0] m_tx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_req  <= 1'b0;
            n_got   <= 0;
            acc     <= '0;
            h_src   <= '0;
            h_addr  <= '0;
            m_wr    <= 1'b0;
            m_err   <= 1'b0;
            m_ovr   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_tx    <= '0;
        end else begin : model
            automatic logic        nin   = in_req;
            automatic int          ng    = n_got;
            automatic logic [31:0] na    = acc;
            automatic logic [7:0]  nsrc  = h_src;
            automatic logic [7:0]  nadr  = h_addr;
            automatic logic        nw    = 1'b0;
            automatic logic        ne    = 1'b0;
            automatic logic        no    = 1'b0;
            automatic logic [7:0]  naddr = m_addr;
            automatic logic [31:0] nwd   = m_wdata;
            automatic logic [34:0] ntx   = m_tx;
            automatic logic [7:0]  s, d, l, b;
            automatic logic        so, eo, v;
            {s, d, l, b, so, eo, v} = rx;
            if (m_tx[0] && ready) ntx[0] = 1'b0;
            if (v) begin
                if (so) begin
                    if (in_req) ne = 1'b1;
                    nin = 1'b0;
                    if (d == WDEST) begin
                        if (l == 8'(DL + 1) && !eo) begin
                            nin  = 1'b1;
                            ng   = 0;
                            na   = '0;
                            nsrc = s;
                            nadr = b;
                        end else begin
                            ne = 1'b1;
                        end
                    end
                end else if (in_req) begin
                    na = na * 256 + 32'(b);
                    ng = ng + 1;
                    if (eo && ng == DL) begin
                        nin   = 1'b0;
                        nw    = 1'b1;
                        naddr = h_addr;
                        nwd   = na;
                        if (m_tx[0] && !ready) no = 1'b1;
                        else ntx = {ASRC, h_src, 8'd1, h_addr, 3'b111};
                    end else if (eo || ng == DL) begin
                        nin = 1'b0;
                        ne  = 1'b1;
                    end
                end
            end
            in_req  <= nin;
            n_got   <= ng;
            acc     <= na;
            h_src   <= nsrc;
            h_addr  <= nadr;
            m_wr    <= nw;
            m_err   <= ne;
            m_ovr   <= no;
            m_addr  <= naddr;
            m_wdata <= nwd;
            m_tx    <= ntx;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("write", 64'(wr), 64'(m_wr));
            check_val("error", 64'(err), 64'(m_err));
            check_val("overrun", 64'(ovr), 64'(m_ovr));
            check_val("address", 64'(addr), 64'(m_addr));
            check_val("wdata", 64'(wdata), 64'(m_wdata));
            check_val("tx_valid", 64'(tx[0]), 64'(m_tx[0]));
            if (m_tx[0]) check_val("tx_packet", 64'(tx), 64'(m_tx));
        end
    end

    task automatic step();
        if (rand_rdy) ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] s, d, l, b, input logic so, eo);
        rx = {s, d, l, b, so, eo, 1'b1};
        step();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            rx = {32'($urandom()), 3'b110};
            step();
        end
        rx = '0;
    endtask

    task automatic send_data(input logic [7:0] s, input logic [31:0] data, input int maxgap);
        for (int i = DL - 1; i >= 0; i--) begin
            if (maxgap > 0) gap($urandom_range(0, maxgap));
            beat(s, WDEST, 8'(DL + 1), data[8*i +: 8], 1'b0, i == 0);
        end
        rx = '0;
    endtask

    task automatic send_req(input logic [7:0] s, a, input logic [31:0] data, input int maxgap);
        beat(s, WDEST, 8'(DL + 1), a, 1'b1, 1'b0);
        send_data(s, data, maxgap);
    endtask

    task automatic rand_pkt();
        automatic int          kind = $urandom_range(0, 9);
        automatic logic [7:0]  s    = 8'($urandom());
        automatic logic [7:0]  a    = 8'($urandom());
        automatic logic [7:0]  d    = (kind == 0) ? 8'h00 : WDEST;
        automatic logic [7:0]  l    = (kind == 1) ? 8'($urandom_range(0, 7)) : 8'(DL + 1);
        automatic int          n    = (kind == 2) ? DL - 1 : (kind == 3) ? DL + 1 :
                                      (kind == 4) ? 2 : DL;
        if (kind == 6) beat(s, d, l, 8'($urandom()), 1'b0, 1'b1);
        beat(s, d, l, a, 1'b1, kind == 5);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
            beat(s, d, l, 8'($urandom()), 1'b0, (kind != 4) && (i == n - 1));
        end
        rx = '0;
        if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 4));
    endtask

    localparam logic [34:0] AckA = {8'h01, 8'h33, 8'h01, 8'h20, 3'b111};

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx", 64'(tx), 64'd0);
        check_val("rst_write", 64'(wr), 64'd0);
        check_val("rst_addr", 64'(addr), 64'd0);
        check_val("rst_wdata", 64'(wdata), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        gap(2);

        // Nominal write
        send_req(8'h5A, 8'h10, 32'hDEADBEEF, 0);
        check_val("nom_write", 64'(wr), 64'd1);
        check_val("nom_addr", 64'(addr), 64'h10);
        check_val("nom_data", 64'(wdata), 64'hDEADBEEF);
        check_val("nom_ack", 64'(tx), 64'({8'h01, 8'h5A, 8'h01, 8'h10, 3'b111}));
        gap(3);

        // Backpressure and overrun
        ready = 1'b0;
        send_req(8'h33, 8'h20, 32'h11223344, 0);
        check_val("bp_write", 64'(wr), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("bp_hold", 64'(tx), 64'(AckA));
        end
        send_req(8'h44, 8'h30, 32'hCAFEF00D, 0);
        check_val("bp2_write", 64'(wr), 64'd1);
        check_val("bp2_overrun", 64'(ovr), 64'd1);
        check_val("bp2_data", 64'(wdata), 64'hCAFEF00D);
        check_val("bp2_ack", 64'(tx), 64'(AckA));
        ready = 1'b1;
        step();
        check_val("bp_release", 64'(tx[0]), 64'd0);
        gap(2);

        // Malformed: wrong length
        beat(8'h12, WDEST, 8'(DL), 8'h40, 1'b1, 1'b0);
        rx = '0;
        check_val("mal_len_err", 64'(err), 64'd1);
        gap(2);
        // Malformed: EoP on 3rd data byte
        beat(8'h12, WDEST, 8'(DL + 1), 8'h41, 1'b1, 1'b0);
        beat(8'h12, WDEST, 8'(DL + 1), 8'hA1, 1'b0, 1'b0);
        beat(8'h12, WDEST, 8'(DL + 1), 8'hA2, 1'b0, 1'b0);
        beat(8'h12, WDEST, 8'(DL + 1), 8'hA3, 1'b0, 1'b1);
        rx = '0;
        check_val("mal_early_err", 64'(err), 64'd1);
        check_val("mal_early_wr", 64'(wr), 64'd0);
        gap(2);
        // Malformed: no EoP on last data byte
        beat(8'h12, WDEST, 8'(DL + 1), 8'h42, 1'b1, 1'b0);
        for (int i = 0; i < DL; i++) beat(8'h12, WDEST, 8'(DL + 1), 8'hB0, 1'b0, 1'b0);
        rx = '0;
        check_val("mal_late_err", 64'(err), 64'd1);
        check_val("mal_late_wr", 64'(wr), 64'd0);
        gap(2);

        // Restart on a new SoP mid-request
        beat(8'h21, WDEST, 8'(DL + 1), 8'h50, 1'b1, 1'b0);
        beat(8'h21, WDEST, 8'(DL + 1), 8'hC1, 1'b0, 1'b0);
        beat(8'h21, WDEST, 8'(DL + 1), 8'hC2, 1'b0, 1'b0);
        beat(8'h66, WDEST, 8'(DL + 1), 8'h60, 1'b1, 1'b0);
        check_val("restart_err", 64'(err), 64'd1);
        send_data(8'h66, 32'h01020304, 0);
        check_val("restart_write", 64'(wr), 64'd1);
        check_val("restart_addr", 64'(addr), 64'h60);
        check_val("restart_data", 64'(wdata), 64'h01020304);
        gap(2);

        // Filtering and gapped request
        beat(8'h70, 8'h00, 8'(DL + 1), 8'h70, 1'b1, 1'b0);
        for (int i = 0; i < DL; i++) beat(8'h70, 8'h00, 8'(DL + 1), 8'h99, 1'b0, i == DL - 1);
        rx = '0;
        check_val("filter_wr", 64'(wr), 64'd0);
        check_val("filter_err", 64'(err), 64'd0);
        send_req(8'h5A, 8'h10, 32'hDEADBEEF, 3);
        check_val("gap_write", 64'(wr), 64'd1);
        check_val("gap_data", 64'(wdata), 64'hDEADBEEF);
        gap(2);

        // Asynchronous reset mid-packet
        beat(8'h5A, WDEST, 8'(DL + 1), 8'h80, 1'b1, 1'b0);
        beat(8'h5A, WDEST, 8'(DL + 1), 8'hDE, 1'b0, 1'b0);
        beat(8'h5A, WDEST, 8'(DL + 1), 8'hAD, 1'b0, 1'b0);
        rx = '0;
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_addr", 64'(addr), 64'd0);
        check_val("arst_wdata", 64'(wdata), 64'd0);
        check_val("arst_tx", 64'(tx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gap(1);
        check_val("arst_no_err", 64'(err), 64'd0);
        send_req(8'h5A, 8'h90, 32'hDEADBEEF, 0);
        check_val("arst_write", 64'(wr), 64'd1);
        check_val("arst_wr_addr", 64'(addr), 64'h90);
        check_val("arst_wr_data", 64'(wdata), 64'hDEADBEEF);
        gap(2);

        // Two-byte build
        rx2 = {8'h77, WDEST, 8'd3, 8'h70, 3'b101};
        @(negedge clk);
        rx2 = {8'h77, WDEST, 8'd3, 8'hBE, 3'b001};
        @(negedge clk);
        rx2 = {8'h77, WDEST, 8'd3, 8'hEF, 3'b011};
        @(negedge clk);
        rx2 = '0;
        check_val("dl2_write", 64'(wr2), 64'd1);
        check_val("dl2_addr", 64'(addr2), 64'h70);
        check_val("dl2_data", 64'(wdata2), 64'h0000BEEF);
        check_val("dl2_err", 64'(err2), 64'd0);

        // Randomized traffic with random transmitter readiness
        rand_rdy = 1'b1;
        for (int p = 0; p < 300; p++) rand_pkt();
        rand_rdy = 1'b0;
        ready    = 1'b1;
        gap(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_write_controller.md
# register_write_controller

Write-side counterpart of the register read path: consumes write-request packets from the UART receive stream, assembles an address plus a DATA_LENGTH-byte big-endian data word, and issues a single-cycle register write strobe. After each successful write it returns a one-byte acknowledge packet on the UART transmit stream. It sits between the UART packet receiver and the register file, in parallel with the read controller.

## Interface

Parameters:
- DATA_LENGTH, 4: data bytes per write, legal 1..4; request Length field must equal DATA_LENGTH+1.
- WRITE_DEST, 8'h01: Destination value identifying write requests.
- ACK_SOURCE, 8'h01: Source value placed in acknowledge packets.

Ports (UART_PACKET = Source[7:0], Destination[7:0], Length[7:0], Data[7:0], SoP, EoP, Valid):
- ipClk  in  1  system clock; all logic on rising edge.
- ipnReset  in  1  asynchronous, active-low reset.
- ipRxStream  in  UART_PACKET  receive stream; one byte per cycle when Valid; no backpressure.
- ipTxReady  in  1  transmitter accepts opTxStream when high with Valid.
- opTxStream  out  UART_PACKET  acknowledge stream.
- opAddress  out  8  register address of the current/last write.
- opWriteData  out  32  write data, right-aligned, upper unused bits zero.
- opWrite  out  1  one-cycle write strobe.
- opError  out  1  one-cycle pulse on malformed request.
- opAckOverrun  out  1  one-cycle pulse when an ack is dropped.

## Operation

- Reset: all outputs 0 (opTxStream fields all 0), state IDLE, byte counter 0, ack-pending clear.
- States: IDLE, GET_DATA, WRITE.
- IDLE: on Valid & SoP & Destination==WRITE_DEST: if Length==DATA_LENGTH+1 and !EoP, latch Data into address register, latch Source as ack destination, clear data shift register, counter<=DATA_LENGTH, go GET_DATA; otherwise pulse opError, stay IDLE. Other destinations, and beats without SoP, are ignored silently.
- GET_DATA, per Valid beat:
  - SoP set: abort, pulse opError, and re-evaluate the beat exactly as IDLE does (restart).
  - Otherwise shift Data in (shreg <= {shreg[23:0], Data}), decrement counter.
  - Counter==1 and EoP: go WRITE.
  - Counter==1 and !EoP, or counter>1 and EoP: pulse opError, go IDLE, no write.
  - Non-Valid cycles: hold.
- WRITE (one cycle): opWrite=1, opAddress and opWriteData updated from the latched values; go IDLE. Ack generation on the same edge:
  - no ack pending: load opTxStream = {Source=ACK_SOURCE, Destination=latched Source, Length=1, Data=address, SoP=1, EoP=1, Valid=1};
  - ack pending: keep the old ack, pulse opAckOverrun; write still happens.
- Ack handshake: opTxStream.Valid stays high and all fields stable until the cycle ipTxReady is sampled high; next cycle Valid=0 (other fields may hold).
- A Valid Rx beat arriving during WRITE is processed as in IDLE.
- opAddress/opWriteData hold until the next write.

## Timing

- opWrite rises one cycle after the clock edge accepting the final (EoP) data byte; minimum 1 cycle, no dependence on ipTxReady.
- Ack Valid asserts in the same cycle as opWrite; it drops one cycle after the ipTxReady handshake.
- Minimum back-to-back request spacing: next SoP may arrive the cycle immediately after WRITE, or during WRITE itself.
- opError/opAckOverrun: exactly one cycle wide, registered.
- Asynchronous reset mid-packet or mid-ack: immediate return to reset values; a partial request is discarded with no write and no error pulse.

## Test plan

- Nominal: Dest 01, Len 5, bytes 10,DE,AD,BE,EF (EoP on last), ipTxReady=1 -> opWrite one cycle after EF, opAddress=0x10, opWriteData=0xDEADBEEF; ack Data=0x10, Length=1, SoP=EoP=1, Destination=request Source.
- Backpressure: ipTxReady=0 for 10 cycles after the write -> ack fields stable with Valid high; ready high -> Valid low next cycle. A second write during the hold -> opWrite=1, opAckOverrun pulse, ack unchanged.
- Malformed: Len 4 -> opError, no write. EoP on the 3rd data byte -> opError, no write. No EoP on the 4th data byte -> opError, no write.
- Restart: SoP of a new valid request after 2 data bytes -> opError pulse, then new request completes with correct address/data.
- Filtering and gaps: Dest 00 request -> no response. Valid request with idle gaps between bytes -> same result as nominal.
- Reset: ipnReset low after the 2nd data byte -> all outputs 0; a following full request writes correctly; DATA_LENGTH=2 build gives opWriteData=0x0000BEEF.
